seg_scan_ctrl: RTL and testbench

Time-multiplexing scheduler that shares one active-low 8-bit segment bus among NUM_DIGITS seven-segment digits. It drives one-cold active-low anodes and inserts a blanking interval between digit slots to suppress ghosting. Upstream hex/sign encoders supply per-digit segment patterns through a load handshake. New patterns are double-buffered and take effect only at frame boundaries, so a displayed value never tears.

---
 rtl/seg_scan_ctrl.sv | 98 +++++++++
 tb/tb_seg_scan_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scanner: one-cold active-low anodes, blanking at each slot start.
// All outputs registered (one cycle from inputs); loads are double-buffered and swap in at frame wrap.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 50000,
    parameter int BLANK      = 500
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          load,
    input  logic [8*NUM_DIGITS-1:0]       digit_data,
    output logic [7:0]                    seg,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          load_ack,
    output logic                          pending
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(DIV - 1);
    localparam logic [IW-1:0] DIGIT_LAST = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, BLNK, SHOW} state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [8*NUM_DIGITS-1:0] active;
    logic [8*NUM_DIGITS-1:0] shadow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            active    <= '1;
            shadow    <= '1;
            seg       <= 8'hFF;
            an        <= '1;
            digit_idx <= '0;
            load_ack  <= 1'b0;
            pending   <= 1'b0;
        end else begin
            load_ack <= 1'b0;
            if (state == IDLE || !enable) begin
                // Display is dark, so nothing can tear: apply new or buffered data at once.
                state     <= enable ? BLNK : IDLE;
                seg       <= 8'hFF;
                an        <= '1;
                digit_idx <= '0;
                cnt       <= '0;
                pending   <= 1'b0;
                if (load) begin
                    active   <= digit_data;
                    load_ack <= 1'b1;
                end else if (pending) begin
                    active   <= shadow;
                    load_ack <= 1'b1;
                end
            end else begin
                if (load) begin
                    shadow  <= digit_data;
                    pending <= 1'b1;
                end
                if (state == BLNK) begin
                    cnt <= cnt + 1'b1;
                    if (cnt == BLANK_LAST) begin
                        state <= SHOW;
                        an    <= ~(NUM_DIGITS'(1) << digit_idx);
                        seg   <= active[8*digit_idx +: 8];
                    end
                end else if (cnt != SLOT_LAST) begin
                    cnt <= cnt + 1'b1;
                end else begin
                    state <= BLNK;
                    cnt   <= '0;
                    an    <= '1;
                    seg   <= 8'hFF;
                    if (digit_idx != DIGIT_LAST) begin
                        digit_idx <= digit_idx + 1'b1;
                    end else begin
                        // Frame boundary: a coincident load bypasses the shadow.
                        digit_idx <= '0;
                        if (load) begin
                            active   <= digit_data;
                            pending  <= 1'b0;
                            load_ack <= 1'b1;
                        end else if (pending) begin
                            active   <= shadow;
                            pending  <= 1'b0;
                            load_ack <= 1'b1;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (4 digits, 8-cycle slots, 2 blank cycles) with a slot scoreboard.
module tb_seg_scan_ctrl;
    localparam int ND = 4;
    localparam int DV = 8;
    localparam int BL = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          load;
    logic [31:0]   digit_data;
    logic [7:0]    seg;
    logic [3:0]    an;
    logic [1:0]    digit_idx;
    logic          load_ack;
    logic          pending;

    seg_scan_ctrl #(.NUM_DIGITS(ND), .DIV(DV), .BLANK(BL)) dut (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .digit_data(digit_data),
        .seg(seg), .an(an), .digit_idx(digit_idx), .load_ack(load_ack), .pending(pending)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int failed   = 0;
    logic [11:0] exp_q[$];
    int ack_cnt = 0;
    int base;
    bit len_chk = 1'b0;
    bit period_chk = 1'b0;

    localparam logic [31:0] D1  = 32'hFFF9A4C0;
    localparam logic [31:0] D2  = 32'h9299B0F9;
    localparam logic [31:0] D3A = 32'hC0C0C0F9;
    localparam logic [31:0] D3B = 32'hF9F9F9A4;
    localparam logic [31:0] D4  = 32'h88838EC6;
    localparam logic [31:0] D5  = 32'hA1C68EF8;
    localparam logic [31:0] D6  = 32'h80808080;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected {an, seg} for the first n digit slots of a frame showing d.
    task automatic push_slots(input logic [31:0] d, input int n);
        for (int k = 0; k < n; k++) begin
            logic [3:0] a;
            a = ~(4'b0001 << k);
            exp_q.push_back({a, d[8*k +: 8]});
        end
    endtask

    // Monitor: scoreboard pop at each SHOW start, slot-length and frame-period checks.
    int cyc = 0;
    int run = 0;
    int last_d0 = 0;
    bit d0_seen = 1'b0;
    bit after_show = 1'b0;
    logic [3:0] prev_an = 4'hF;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_an    = 4'hF;
            run        = 0;
            after_show = 1'b0;
        end else begin
            if (an != 4'hF && prev_an == 4'hF) begin
                if (len_chk && after_show) chk("blank_len", run, BL);
                chk("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("slot_an_seg", {an, seg}, exp_q.pop_front());
                if (an == 4'b1110) begin
                    if (period_chk && d0_seen) chk("frame_period", cyc - last_d0, ND * DV);
                    last_d0 = cyc;
                    d0_seen = 1'b1;
                end
                run = 1;
            end else if (an == 4'hF && prev_an != 4'hF) begin
                if (len_chk) chk("show_len", run, DV - BL);
                after_show = 1'b1;
                run = 1;
            end else begin
                run++;
            end
            if (!len_chk) after_show = 1'b0;
            if (!period_chk) d0_seen = 1'b0;
            if (load_ack) ack_cnt++;
            prev_an = an;
        end
    end

    initial begin
        rst = 1'b1; enable = 1'b0; load = 1'b0; digit_data = '1;
        #2;
        chk("rst_seg", seg, 8'hFF);
        chk("rst_an", an, 4'hF);
        chk("rst_idx", digit_idx, 0);
        chk("rst_ack", load_ack, 0);
        chk("rst_pending", pending, 0);
        step(2);
        rst = 1'b0;
        step(1);

        // Load while idle applies immediately
        load = 1'b1; digit_data = D1;
        step(1);
        load = 1'b0;
        chk("idle_ack", load_ack, 1);
        chk("idle_pending", pending, 0);
        step(1);
        chk("idle_ack_end", load_ack, 0);

        // Test 1: basic scan (edge numbering: enable sampled at edge 1)
        push_slots(D1, 4);
        push_slots(D1, 4);
        enable = 1'b1; len_chk = 1'b1; period_chk = 1'b1;
        step(1);
        chk("t1_blank_an", an, 4'hF);
        chk("t1_blank_seg", seg, 8'hFF);
        chk("t1_blank_idx", digit_idx, 0);
        step(2);
        chk("t1_show0_an", an, 4'b1110);
        chk("t1_show0_seg", seg, 8'hC0);

        // Test 2: mid-frame load during digit 1 of frame 1 (edge 44)
        step(40);
        load = 1'b1; digit_data = D2;
        step(1);
        load = 1'b0;
        base = ack_cnt;
        chk("t2_pending", pending, 1);
        chk("t2_idx", digit_idx, 1);
        push_slots(D2, 4);
        step(20);
        chk("t2_pending_hold", pending, 1);
        chk("t2_no_early_ack", ack_cnt - base, 0);
        step(1);
        chk("t2_wrap_ack", load_ack, 1);
        chk("t2_wrap_pending", pending, 0);
        chk("t2_wrap_idx", digit_idx, 0);
        step(1);
        chk("t2_ack_end", load_ack, 0);
        chk("t2_ack_once", ack_cnt - base, 1);

        // Test 3: two loads in frame 2, last one wins
        base = ack_cnt;
        push_slots(D3B, 4);
        step(3);
        load = 1'b1; digit_data = D3A;
        step(1);
        load = 1'b0;
        chk("t3_pending_a", pending, 1);
        step(9);
        load = 1'b1; digit_data = D3B;
        step(1);
        load = 1'b0;
        chk("t3_pending_b", pending, 1);
        step(16);
        chk("t3_no_early_ack", ack_cnt - base, 0);
        step(1);
        chk("t3_wrap_ack", load_ack, 1);
        chk("t3_wrap_pending", pending, 0);
        step(31);
        chk("t3_ack_once", ack_cnt - base, 1);

        // Test 4: load on the exact wrap edge (edge 129)
        base = ack_cnt;
        load = 1'b1; digit_data = D4;
        step(1);
        load = 1'b0;
        chk("t4_ack", load_ack, 1);
        push_slots(D4, 4);
        for (int i = 0; i < 8; i++) begin
            chk("t4_pending_low", pending, 0);
            step(1);
        end
        step(23);
        chk("t4_ack_once", ack_cnt - base, 1);

        // Test 5: drop enable in digit 2 SHOW with data pending
        push_slots(D4, 3);
        step(4);
        load = 1'b1; digit_data = D5;
        step(1);
        load = 1'b0;
        chk("t5_pending", pending, 1);
        step(15);
        chk("t5_show2_an", an, 4'b1011);
        len_chk = 1'b0; period_chk = 1'b0;
        enable = 1'b0;
        step(1);
        chk("t5_dark_an", an, 4'hF);
        chk("t5_dark_seg", seg, 8'hFF);
        chk("t5_dark_idx", digit_idx, 0);
        chk("t5_ack", load_ack, 1);
        chk("t5_pending_clr", pending, 0);
        step(3);
        chk("t5_idle_an", an, 4'hF);
        push_slots(D5, 4);
        enable = 1'b1;
        step(1);
        chk("t5_reblank1", an, 4'hF);
        step(1);
        chk("t5_reblank2", an, 4'hF);
        step(1);
        chk("t5_re_show0_an", an, 4'b1110);
        chk("t5_re_show0_seg", seg, D5[7:0]);
        len_chk = 1'b1;

        // Test 6: asynchronous reset mid-SHOW with data pending
        load = 1'b1; digit_data = D6;
        step(1);
        load = 1'b0;
        chk("t6_pending_pre", pending, 1);
        #3;
        rst = 1'b1; len_chk = 1'b0;
        #1;
        chk("t6_an", an, 4'hF);
        chk("t6_seg", seg, 8'hFF);
        chk("t6_pending", pending, 0);
        chk("t6_idx", digit_idx, 0);
        exp_q.delete();
        step(1);
        rst = 1'b0;
        // Buffers were cleared: the next frame must be blank patterns.
        push_slots(32'hFFFFFFFF, 4);
        step(34);
        chk("t6_sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
